// File: rtl/likealu_arbiter_pkg.sv
// Shared constants for the likeALU arbiter slice.
// State encodings, port ids and default datapath widths.
package likealu_arbiter_pkg;

    localparam int WIDTH_DEF = 5;
    localparam int SELW_DEF  = 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/likealu_arbiter_likealu.sv
// Combinational likeALU datapath.
// Select: 0 add, 1 sub (A-B), 2 and, 3 xor; results wrap to WIDTH bits.
module likealu #(
    parameter int WIDTH = 5,
    parameter int SELW  = 2
) (
    input  logic [WIDTH-1:0] InpA,
    input  logic [WIDTH-1:0] InpB,
    input  logic [SELW-1:0]  Select,
    output logic [WIDTH-1:0] Out
);

    always_comb begin
        Out = '0;
        case (Select)
            SELW'(0): Out = InpA + InpB;
            SELW'(1): Out = InpA - InpB;
            SELW'(2): Out = InpA & InpB;
            SELW'(3): Out = InpA ^ InpB;
            default:  Out = '0;
        endcase
    end

endmodule

// File: rtl/likealu_arbiter.sv
// Round-robin sharing of one likeALU between two requesters.
// Operands are latched at grant; the result is registered in EXEC.
module likealu_arbiter
    import likealu_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SELW  = SELW_DEF,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [SELW-1:0]  sel0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [SELW-1:0]  sel1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic [CNTW-1:0]  op_count
);

    logic [1:0]       state;
    logic             grant;
    logic             last_grant;
    logic [WIDTH-1:0] lat_a;
    logic [WIDTH-1:0] lat_b;
    logic [SELW-1:0]  lat_sel;
    logic [WIDTH-1:0] alu_out;
    logic             winner;

    // On a tie the port that did not win last time goes next.
    function automatic logic arb(input logic r0, input logic r1,
                                 input logic last);
        if (r0 && r1)
            return ~last;
        else if (r0)
            return PORT0;
        else
            return PORT1;
    endfunction

    assign winner = arb(req0, req1, last_grant);

    likealu #(
        .WIDTH (WIDTH),
        .SELW  (SELW)
    ) u_alu (
        .InpA   (lat_a),
        .InpB   (lat_b),
        .Select (lat_sel),
        .Out    (alu_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= PORT0;
            last_grant <= PORT1;
            lat_a      <= '0;
            lat_b      <= '0;
            lat_sel    <= '0;
            result     <= '0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant   <= winner;
                        lat_a   <= (winner == PORT1) ? a1 : a0;
                        lat_b   <= (winner == PORT1) ? b1 : b0;
                        lat_sel <= (winner == PORT1) ? sel1 : sel0;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    result <= alu_out;
                    state  <= RESP;
                end
                RESP: begin
                    last_grant <= grant;
                    op_count   <= op_count + 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy  = (state == EXEC) || (state == RESP);
    assign done0 = (state == RESP) && (grant == PORT0);
    assign done1 = (state == RESP) && (grant == PORT1);

endmodule

// File: tb/tb_likealu_arbiter.sv
// Directed bench for likealu_arbiter: vector table plus
// hand sequences for ties, stability, drops, reset and wrap.
module tb_likealu_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [4:0] a0, b0, a1, b1;
    logic [1:0] sel0, sel1;
    logic       done0, done1, busy;
    logic [4:0] result;
    logic [7:0] op_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    likealu_arbiter #(.WIDTH(5), .SELW(2), .CNTW(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .a0       (a0),
        .b0       (b0),
        .sel0     (sel0),
        .req1     (req1),
        .a1       (a1),
        .b1       (b1),
        .sel1     (sel1),
        .done0    (done0),
        .done1    (done1),
        .result   (result),
        .busy     (busy),
        .op_count (op_count)
    );

    typedef struct {
        logic       r0;
        logic [4:0] a0, b0;
        logic [1:0] s0;
        logic       r1;
        logic [4:0] a1, b1;
        logic [1:0] s1;
        logic       port;
        logic [4:0] res;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0 = 0; req1 = 0;
        a0 = 0; b0 = 0; sel0 = 0;
        a1 = 0; b1 = 0; sel1 = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Waits (bounded) for a done pulse; sampled on negedges.
    task automatic wait_done(output int cyc, output logic p,
                             output logic got);
        got = 0; cyc = 0; p = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cyc++;
            if (done0 || done1) begin
                got = 1;
                p = done1;
                break;
            end
        end
    endtask

    initial begin
        int   cyc;
        logic p, got;
        logic quiet;
        int   nops;

        vecs[0] = '{1, 5'b00010, 5'b11100, 2'd0, 0, 5'd0, 5'd0, 2'd0,
                    0, 5'b11110};
        vecs[1] = '{0, 5'd0, 5'd0, 2'd0, 1, 5'b00100, 5'b11100, 2'd3,
                    1, 5'b11000};
        vecs[2] = '{1, 5'b10001, 5'b01101, 2'd1, 1, 5'b01000, 5'b11100,
                    2'd2, 0, 5'b00100};
        vecs[3] = '{1, 5'b10001, 5'b01101, 2'd1, 1, 5'b01000, 5'b11100,
                    2'd2, 1, 5'b01000};
        vecs[4] = '{0, 5'd0, 5'd0, 2'd0, 1, 5'b00011, 5'b00101, 2'd1,
                    1, 5'b11110};
        vecs[5] = '{1, 5'b11111, 5'b00001, 2'd0, 1, 5'b11111, 5'b11111,
                    2'd3, 0, 5'b00000};
        vecs[6] = '{1, 5'b10101, 5'b01111, 2'd2, 0, 5'd0, 5'd0, 2'd0,
                    0, 5'b00101};

        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_done", {done1, done0}, 0);
        chk("rst_result", result, 0);
        chk("rst_count", op_count, 0);

        foreach (vecs[i]) begin
            req0 = vecs[i].r0; a0 = vecs[i].a0;
            b0 = vecs[i].b0;   sel0 = vecs[i].s0;
            req1 = vecs[i].r1; a1 = vecs[i].a1;
            b1 = vecs[i].b1;   sel1 = vecs[i].s1;
            @(negedge clk);
            chk($sformatf("v%0d_busy_exec", i), busy, 1);
            wait_done(cyc, p, got);
            chk($sformatf("v%0d_done", i), got, 1);
            chk($sformatf("v%0d_lat", i), cyc, 1);
            chk($sformatf("v%0d_busy_resp", i), busy, 1);
            chk($sformatf("v%0d_onehot", i), done0 & done1, 0);
            chk($sformatf("v%0d_port", i), p, vecs[i].port);
            chk($sformatf("v%0d_result", i), result, vecs[i].res);
            chk($sformatf("v%0d_cnt_resp", i), op_count, i);
            req0 = 0; req1 = 0;
            @(negedge clk);
            chk($sformatf("v%0d_idle", i), busy, 0);
            chk($sformatf("v%0d_cnt", i), op_count, i + 1);
        end

        // Continuous tie: grants alternate 0,1,0,1 at 3-cycle spacing.
        do_reset();
        req0 = 1; a0 = 5'b10001; b0 = 5'b01101; sel0 = 2'd1;
        req1 = 1; a1 = 5'b01000; b1 = 5'b11100; sel1 = 2'd2;
        for (int k = 0; k < 4; k++) begin
            wait_done(cyc, p, got);
            chk($sformatf("tie%0d_done", k), got, 1);
            chk($sformatf("tie%0d_gap", k), cyc, (k == 0) ? 2 : 3);
            chk($sformatf("tie%0d_port", k), p, k % 2);
            chk($sformatf("tie%0d_result", k), result,
                (k % 2) ? 5'b01000 : 5'b00100);
        end
        req0 = 0; req1 = 0;
        @(negedge clk);
        chk("tie_count", op_count, 4);

        // Operands and request change while EXEC is in flight.
        do_reset();
        req1 = 1; a1 = 5'b00100; b1 = 5'b11100; sel1 = 2'd3;
        @(negedge clk);
        a1 = 5'b10101; req1 = 0;
        wait_done(cyc, p, got);
        chk("stab_done", got, 1);
        chk("stab_port", p, 1);
        chk("stab_result", result, 5'b11000);
        @(negedge clk);

        // Dropped request still completes once, then FSM idles.
        req0 = 1; a0 = 5'b00111; b0 = 5'b00001; sel0 = 2'd0;
        @(negedge clk);
        req0 = 0;
        wait_done(cyc, p, got);
        chk("drop_done", got & ~p, 1);
        chk("drop_result", result, 5'b01000);
        quiet = 1;
        repeat (4) begin
            @(negedge clk);
            if (busy || done0 || done1) quiet = 0;
        end
        chk("drop_quiet", quiet, 1);
        chk("drop_count", op_count, 2);

        // Reset in EXEC aborts silently and restores tie priority.
        req1 = 1; a1 = 5'b00001; b1 = 5'b00001; sel1 = 2'd0;
        @(negedge clk);
        chk("mid_busy_pre", busy, 1);
        reset = 1; req1 = 0;
        @(negedge clk);
        chk("mid_busy", busy, 0);
        chk("mid_result", result, 0);
        chk("mid_count", op_count, 0);
        chk("mid_done", {done1, done0}, 0);
        reset = 0;
        req0 = 1; a0 = 5'b00011; b0 = 5'b00001; sel0 = 2'd1;
        req1 = 1; a1 = 5'b00011; b1 = 5'b00001; sel1 = 2'd0;
        wait_done(cyc, p, got);
        chk("mid_tie_done", got, 1);
        chk("mid_tie_port", p, 0);
        chk("mid_tie_result", result, 5'b00010);
        req0 = 0; req1 = 0;
        @(negedge clk);

        // 256 back-to-back ops wrap the counter to zero.
        do_reset();
        req0 = 1; a0 = 5'd1; b0 = 5'd1; sel0 = 2'd0;
        nops = 0;
        for (int k = 0; k < 256; k++) begin
            wait_done(cyc, p, got);
            if (!got) break;
            nops++;
        end
        chk("wrap_ops", nops, 256);
        chk("wrap_pre", op_count, 255);
        req0 = 0;
        @(negedge clk);
        chk("wrap_count", op_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
